// File: rtl/spart_pkg.sv
// Shared types and constants for the parametrised SPART receive path.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam int unsigned SPART_DIV_MIN = 3;

endpackage

// File: rtl/spart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module spart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rd];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop_ok) r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spart_rx_param.sv
// Parametrised SPART receiver: synchroniser, mid-bit sampling FSM with
// parity/stop/break checking, sticky error flags and a FWFT receive FIFO.
module spart_rx_param
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [15:0]          divisor_buffer,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic [CNT_W-1:0]     rx_count,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int BCW = $clog2(DATA_BITS+1);
  localparam logic [BCW-1:0] BITS_INIT = BCW'(DATA_BITS);

  rx_state_t            r_state, w_next;
  logic                 r_sync1, r_sync2, w_rxs;
  logic [15:0]          r_cnt, r_div;
  logic [BCW-1:0]       r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en, r_par_odd, r_two_stop;
  logic                 r_stop2, r_pe_pend, r_all_zero;
  logic                 r_fe, r_pe, r_ovr, r_brk;
  logic                 w_tick, w_push, w_set_fe, w_set_pe, w_set_brk;
  logic                 w_pop, w_full, w_empty;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_cnt == '0);
  assign w_pop  = rd_en && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_state <= w_next;
    end
  end

  // Frame decision happens in the cycle of the final stop sample.
  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_set_fe  = 1'b0;
    w_set_pe  = 1'b0;
    w_set_brk = 1'b0;
    case (r_state)
      IDLE:     if (!w_rxs) w_next = START;
      START:    if (w_tick) w_next = w_rxs ? IDLE : DATA;
      DATA:     if (w_tick && r_bitcnt == BCW'(1)) w_next = r_par_en ? PARITY : STOP;
      PARITY:   if (w_tick) w_next = STOP;
      STOP: begin
        if (w_tick) begin
          if (!w_rxs) begin
            w_set_fe  = 1'b1;
            w_set_pe  = r_pe_pend;
            w_set_brk = r_all_zero;
            w_next    = BRK_WAIT;
          end else if (!(r_two_stop && !r_stop2)) begin
            w_set_pe = r_pe_pend;
            w_push   = !r_pe_pend;
            w_next   = IDLE;
          end
        end
      end
      BRK_WAIT: if (w_rxs) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_pe_pend  <= 1'b0;
      r_all_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_cnt      <= divisor_buffer >> 1;
            r_div      <= divisor_buffer;
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_two_stop <= two_stop;
            r_stop2    <= 1'b0;
            r_pe_pend  <= 1'b0;
            r_all_zero <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_cnt    <= r_div;
            r_bitcnt <= BITS_INIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt      <= r_div;
            r_shift    <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_bitcnt   <= r_bitcnt - 1'b1;
            r_all_zero <= r_all_zero & ~w_rxs;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_cnt      <= r_div;
            r_pe_pend  <= (w_rxs != (^r_shift ^ r_par_odd));
            r_all_zero <= r_all_zero & ~w_rxs;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt   <= r_div;
            r_stop2 <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky flags: a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fe  <= 1'b0;
      r_pe  <= 1'b0;
      r_ovr <= 1'b0;
      r_brk <= 1'b0;
    end else begin
      r_fe  <= w_set_fe  | (r_fe  & ~err_clr);
      r_pe  <= w_set_pe  | (r_pe  & ~err_clr);
      r_brk <= w_set_brk | (r_brk & ~err_clr);
      r_ovr <= (w_push & w_full & ~w_pop) | (r_ovr & ~err_clr);
    end
  end

  spart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (rx_data),
    .count (rx_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rda         = !w_empty;
  assign framing_err = r_fe;
  assign parity_err  = r_pe;
  assign overrun     = r_ovr;
  assign break_det   = r_brk;

endmodule

// File: tb/tb_spart_rx_param.sv
// Directed bench for spart_rx_param: 8-bit and 7-bit receivers, frame table
// plus hand-written glitch, overrun, break, two-stop and reset sequences.
module tb_spart_rx_param;

  logic        clk = 1'b0;
  logic        rst, rxd8, rxd7, parity_en, parity_odd, two_stop;
  logic        rd8, rd7, clr8, clr7;
  logic [15:0] div;
  logic [7:0]  d8;
  logic [6:0]  d7;
  logic [2:0]  cnt8, cnt7;
  logic        rda8, fe8, pe8, ov8, bk8;
  logic        rda7, fe7, pe7, ov7, bk7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spart_rx_param #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst(rst), .rxd(rxd8), .divisor_buffer(div),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rd_en(rd8), .err_clr(clr8), .rx_data(d8), .rda(rda8), .rx_count(cnt8),
    .framing_err(fe8), .parity_err(pe8), .overrun(ov8), .break_det(bk8)
  );

  spart_rx_param #(.DATA_BITS(7), .FIFO_DEPTH(4)) u_dut7 (
    .clk(clk), .rst(rst), .rxd(rxd7), .divisor_buffer(div),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rd_en(rd7), .err_clr(clr7), .rx_data(d7), .rda(rda7), .rx_count(cnt7),
    .framing_err(fe7), .parity_err(pe7), .overrun(ov7), .break_det(bk7)
  );

  typedef struct {
    logic [7:0] data;
    logic       pen, podd, pbit, stop;
    logic       e_push, e_fe, e_pe, e_brk;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bitp(input int tgt, input logic v);
    if (tgt == 7) rxd7 = v; else rxd8 = v;
    repeat (int'(div) + 1) @(posedge clk);
    #1;
  endtask

  task automatic send(input int tgt, input logic [8:0] data, input int nbits,
                      input logic pen, input logic pbit, input logic s1,
                      input logic dos2, input logic s2);
    @(posedge clk); #1;
    bitp(tgt, 1'b0);
    for (int i = 0; i < nbits; i++) bitp(tgt, data[i]);
    if (pen) bitp(tgt, pbit);
    bitp(tgt, s1);
    if (dos2) bitp(tgt, s2);
    if (tgt == 7) rxd7 = 1'b1; else rxd8 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop8();
    rd8 = 1'b1; @(posedge clk); #1; rd8 = 1'b0;
  endtask

  task automatic clear8();
    clr8 = 1'b1; @(posedge clk); #1; clr8 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; rxd8 = 1'b1; rxd7 = 1'b1; div = 16'd15;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    rd8 = 1'b0; rd7 = 1'b0; clr8 = 1'b0; clr7 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rda8", 32'(rda8), 32'd0);
    chk("reset_data8", 32'(d8), 32'd0);
    chk("reset_cnt8", 32'(cnt8), 32'd0);
    chk("reset_flags8", 32'({fe8, pe8, ov8, bk8}), 32'd0);
    chk("reset_rda7", 32'(rda7), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      parity_en  = vecs[v].pen;
      parity_odd = vecs[v].podd;
      send(8, {1'b0, vecs[v].data}, 8, vecs[v].pen, vecs[v].pbit, vecs[v].stop, 1'b0, 1'b1);
      chk($sformatf("v%0d_rda", v), 32'(rda8), 32'(vecs[v].e_push));
      chk($sformatf("v%0d_fe", v), 32'(fe8), 32'(vecs[v].e_fe));
      chk($sformatf("v%0d_pe", v), 32'(pe8), 32'(vecs[v].e_pe));
      chk($sformatf("v%0d_brk", v), 32'(bk8), 32'(vecs[v].e_brk));
      chk($sformatf("v%0d_ovr", v), 32'(ov8), 32'd0);
      if (vecs[v].e_push) begin
        chk($sformatf("v%0d_data", v), 32'(d8), 32'(vecs[v].data));
        chk($sformatf("v%0d_cnt", v), 32'(cnt8), 32'd1);
        pop8();
        chk($sformatf("v%0d_rda_after_pop", v), 32'(rda8), 32'd0);
      end else begin
        clear8();
        chk($sformatf("v%0d_flags_cleared", v), 32'({fe8, pe8, bk8}), 32'd0);
      end
    end
    parity_en = 1'b0; parity_odd = 1'b0;

    // Short low glitch must abort in START without flags.
    @(posedge clk); #1; rxd8 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rxd8 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_rda", 32'(rda8), 32'd0);
    chk("glitch_flags", 32'({fe8, pe8, ov8, bk8}), 32'd0);
    send(8, 9'h05C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_glitch_data", 32'(d8), 32'h5C);
    pop8();

    // 7-bit receiver, even parity, wrong then right parity bit.
    parity_en = 1'b1; parity_odd = 1'b0;
    send(7, 9'h035, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("p7_pe", 32'(pe7), 32'd1);
    chk("p7_rda", 32'(rda7), 32'd0);
    chk("p7_fe", 32'(fe7), 32'd0);
    clr7 = 1'b1; @(posedge clk); #1; clr7 = 1'b0;
    chk("p7_pe_clr", 32'(pe7), 32'd0);
    send(7, 9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("p7_good_rda", 32'(rda7), 32'd1);
    chk("p7_good_data", 32'(d7), 32'h35);
    chk("p7_good_pe", 32'(pe7), 32'd0);
    parity_en = 1'b0;

    // Overrun: five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send(8, 9'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_cnt", 32'(cnt8), 32'd4);
    chk("ovr_flag", 32'(ov8), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_pop%0d", i), 32'(d8), 32'(i));
      pop8();
    end
    chk("ovr_empty", 32'(rda8), 32'd0);
    clear8();
    chk("ovr_clr", 32'(ov8), 32'd0);
    for (int i = 1; i <= 4; i++) send(8, 9'(16 + i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // Push lands on the 155th edge after the start bit is driven (div=15).
    fork
      send(8, 9'h015, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1; rd8 = 1'b1;
        @(posedge clk);
        #1; rd8 = 1'b0;
      end
    join
    chk("pp_ovr", 32'(ov8), 32'd0);
    chk("pp_cnt", 32'(cnt8), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("pp_pop%0d", i), 32'(d8), 32'(16 + i));
      pop8();
    end

    // Line held low for 30 bit periods: one error frame only.
    @(posedge clk); #1; rxd8 = 1'b0;
    repeat (12 * 16) @(posedge clk);
    #1;
    chk("brk_fe", 32'(fe8), 32'd1);
    chk("brk_det", 32'(bk8), 32'd1);
    chk("brk_rda", 32'(rda8), 32'd0);
    chk("brk_pe", 32'(pe8), 32'd0);
    clear8();
    repeat (18 * 16) @(posedge clk);
    #1;
    chk("brk_once", 32'({fe8, bk8, rda8}), 32'd0);
    rxd8 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("brk_release", 32'({fe8, bk8, rda8}), 32'd0);
    send(8, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("brk_recover_rda", 32'(rda8), 32'd1);
    chk("brk_recover_data", 32'(d8), 32'h3C);
    pop8();

    // Two stop bits.
    two_stop = 1'b1;
    send(8, 9'h06E, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_fe", 32'(fe8), 32'd1);
    chk("ts_brk", 32'(bk8), 32'd0);
    chk("ts_rda", 32'(rda8), 32'd0);
    clear8();
    send(8, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("ts_good_data", 32'({rda8, d8}), 32'h1C3);
    chk("ts_good_fe", 32'(fe8), 32'd0);
    pop8();
    fork
      send(8, 9'h042, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #1; two_stop = 1'b0;
      end
    join
    chk("ts_toggle_fe", 32'(fe8), 32'd1);
    chk("ts_toggle_rda", 32'(rda8), 32'd0);
    clear8();

    // Reset in the middle of a frame.
    fork
      send(8, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (80) @(posedge clk);
        #3; rst = 1'b0;
      end
    join
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_rda", 32'(rda8), 32'd0);
    chk("midrst_flags", 32'({fe8, pe8, ov8, bk8}), 32'd0);
    chk("midrst_cnt", 32'(cnt8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
